// File: rtl/add2c_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add2c_pipe: pipelined sign-magnitude float adder/subtractor (capture + 3   |
// | stages). Define ADD2C_PIPE_ROUND_EN for round-to-nearest-even, else trunc. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module add2c_pipe #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] x,
  input  logic [EXP_W+FRAC_W:0] y,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] z,
  output logic                  ovf,
  output logic                  unf
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 4;   // {hidden, frac, guard, round, sticky}
  localparam int AW = FRAC_W + 5;
  localparam int XW = EXP_W + 7;    // signed headroom for exponent arithmetic

  logic                 w_en;
  logic                 r_v1, r_v2, r_v3, r_vo;
  logic [W-1:0]         r1_x, r1_y;
  logic                 w_x_big;
  logic [W-1:0]         w_big;
  logic [W-2:0]         w_sml;
  logic [EXP_W-1:0]     w_d;
  logic [MW-1:0]        w_ml, w_ms, w_ms_sh;
  logic                 w_lost;
  logic                 r2_sign, r2_op;
  logic [EXP_W-1:0]     r2_exp;
  logic [MW-1:0]        r2_ml, r2_ms;
  logic [AW-1:0]        w_sum;
  logic                 r3_sign;
  logic [EXP_W-1:0]     r3_exp;
  logic [AW-1:0]        r3_sum;
  logic [5:0]           w_lz;
  logic [MW-1:0]        w_nm;
  logic [XW-1:0]        w_ne, w_re;
  logic                 w_rup;
  logic [FRAC_W+1:0]    w_mr;
  logic [FRAC_W-1:0]    w_frac;
  logic [W-1:0]         w_z;
  logic                 w_ovf, w_unf;
  logic [W-1:0]         r_z;
  logic                 r_ovf, r_unf;

  assign w_en      = !r_vo || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vo;
  assign z         = r_z;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r1_x <= '0;
      r1_y <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r1_x <= x;
      r1_y <= {y[W-1] ^ sub, y[W-2:0]};
    end
  end

  // Zero operands get a zero mantissa so they fall out of the normal add path.
  always_comb begin
    w_x_big = r1_x[W-2:0] > r1_y[W-2:0];
    w_big   = w_x_big ? r1_x : r1_y;
    w_sml   = w_x_big ? r1_y[W-2:0] : r1_x[W-2:0];
    w_d     = w_big[W-2:FRAC_W] - w_sml[W-2:FRAC_W];
    w_ml    = (w_big[W-2:0] == '0) ? '0 : {1'b1, w_big[FRAC_W-1:0], 3'b000};
    w_ms    = (w_sml == '0) ? '0 : {1'b1, w_sml[FRAC_W-1:0], 3'b000};
    w_ms_sh = w_ms >> w_d;
    w_lost  = |(w_ms & ~({MW{1'b1}} << w_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r2_sign <= 1'b0;
      r2_op   <= 1'b0;
      r2_exp  <= '0;
      r2_ml   <= '0;
      r2_ms   <= '0;
    end else if (w_en) begin
      r_v2    <= r_v1;
      r2_sign <= w_big[W-1];
      r2_op   <= r1_x[W-1] ^ r1_y[W-1];
      r2_exp  <= w_big[W-2:FRAC_W];
      r2_ml   <= w_ml;
      r2_ms   <= w_ms_sh | {{(MW-1){1'b0}}, w_lost};
    end
  end

  assign w_sum = r2_op ? ({1'b0, r2_ml} - {1'b0, r2_ms})
                       : ({1'b0, r2_ml} + {1'b0, r2_ms});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3    <= 1'b0;
      r3_sign <= 1'b0;
      r3_exp  <= '0;
      r3_sum  <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r3_sign <= r2_sign;
      r3_exp  <= r2_exp;
      r3_sum  <= w_sum;
    end
  end

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < MW; i++) begin
      if (r3_sum[i]) w_lz = 6'(MW - 1 - i);
    end
    if (r3_sum[AW-1]) begin
      w_nm = r3_sum[AW-1:1] | {{(MW-1){1'b0}}, r3_sum[0]};
      w_ne = {{(XW-EXP_W){1'b0}}, r3_exp} + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      w_nm = r3_sum[MW-1:0] << w_lz;
      w_ne = {{(XW-EXP_W){1'b0}}, r3_exp} - {{(XW-6){1'b0}}, w_lz};
    end
  end

`ifdef ADD2C_PIPE_ROUND_EN
  assign w_rup = w_nm[2] & (w_nm[1] | w_nm[0] | w_nm[3]);
`else
  logic w_grs_unused;
  assign w_grs_unused = ^w_nm[2:0];
  assign w_rup        = 1'b0;
`endif

  // A rounding carry out of all-ones fraction bumps the exponent and may overflow.
  always_comb begin
    w_mr = {1'b0, w_nm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, w_rup};
    if (w_mr[FRAC_W+1]) begin
      w_frac = w_mr[FRAC_W:1];
      w_re   = w_ne + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      w_frac = w_mr[FRAC_W-1:0];
      w_re   = w_ne;
    end
    w_z   = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r3_sum != '0) begin
      if (w_re[XW-1]) begin
        w_unf = 1'b1;
      end else if (|w_re[XW-2:EXP_W]) begin
        w_z   = {r3_sign, {(W-1){1'b1}}};
        w_ovf = 1'b1;
      end else begin
        w_z = {r3_sign, w_re[EXP_W-1:0], w_frac};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vo  <= 1'b0;
      r_z   <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_en) begin
      r_vo  <= r_v3;
      r_z   <= w_z;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end
endmodule
`default_nettype wire
